// File: rtl/ram32_byte_bridge.sv
`timescale 1ns/1ps
// Byte-serial command front end for the 32x32 RAM macro; read words stream back LSB first.
// Define BRIDGE_BYTE_MASK_EN to take a byte-enable mask byte after each write command.
module ram32_byte_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        ABORT,
  output logic        RAM_EN,
  output logic [3:0]  RAM_WE,
  output logic [4:0]  RAM_A,
  output logic [31:0] RAM_DI,
  input  logic [31:0] RAM_DO
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef BRIDGE_BYTE_MASK_EN
    WMASK,
`endif
    WDATA,
    WRITE,
    RREQ,
    RCAP,
    RSEND
  } state_t;

`ifdef BRIDGE_BYTE_MASK_EN
  localparam state_t FIRST_W = WMASK;
`else
  localparam state_t FIRST_W = WDATA;
`endif

  state_t           state;
  state_t           state_nxt;
  logic             live;
  logic             accepting;
  logic             in_xfer;
  logic             out_xfer;
  logic             to_hit;
  logic             do_abort;
  logic             abort_q;
  logic [4:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      shreg;
  logic [1:0]       bcnt;
  logic [1:0]       ocnt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       we_word;

`ifdef BRIDGE_BYTE_MASK_EN
  logic [3:0] mask;
  assign we_word = mask;
`else
  assign we_word = 4'hF;
`endif

  // live holds IN_READY low until the first edge after reset release
  always_comb begin
    accepting = (state == IDLE) || (state == WDATA);
`ifdef BRIDGE_BYTE_MASK_EN
    if (state == WMASK) accepting = 1'b1;
`endif
  end

  assign IN_READY  = live && accepting;
  assign in_xfer   = IN_VALID && IN_READY;
  assign OUT_VALID = (state == RSEND);
  assign out_xfer  = OUT_VALID && OUT_READY;
  assign OUT_DATA  = shreg[7:0];
  assign ABORT     = abort_q;
  assign RAM_EN    = (state == WRITE) || (state == RREQ);
  assign RAM_WE    = (state == WRITE) ? we_word : 4'h0;
  assign RAM_A     = addr;
  assign RAM_DI    = wdata;
  assign to_hit    = (TIMEOUT != 0) && ((cnt + 1'b1) == CNT_W'(TIMEOUT));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // An accepted byte always beats a timeout expiring on the same edge
  always_comb begin
    state_nxt = state;
    do_abort  = 1'b0;
    case (state)
      IDLE: if (in_xfer) state_nxt = IN_DATA[7] ? FIRST_W : RREQ;
`ifdef BRIDGE_BYTE_MASK_EN
      WMASK: begin
        if (in_xfer) begin
          state_nxt = WDATA;
        end else if (to_hit) begin
          state_nxt = IDLE;
          do_abort  = 1'b1;
        end
      end
`endif
      WDATA: begin
        if (in_xfer) begin
          if (bcnt == 2'd3) state_nxt = WRITE;
        end else if (to_hit) begin
          state_nxt = IDLE;
          do_abort  = 1'b1;
        end
      end
      WRITE: state_nxt = IDLE;
      RREQ:  state_nxt = RCAP;
      RCAP:  state_nxt = RSEND;
      RSEND: if (out_xfer && ocnt == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      live    <= 1'b0;
      abort_q <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      shreg   <= '0;
      bcnt    <= '0;
      ocnt    <= '0;
      cnt     <= '0;
`ifdef BRIDGE_BYTE_MASK_EN
      mask    <= '0;
`endif
    end else begin
      live    <= 1'b1;
      abort_q <= do_abort;
      case (state)
        IDLE: begin
          if (in_xfer) begin
            addr <= IN_DATA[4:0];
            bcnt <= '0;
            cnt  <= '0;
          end
        end
`ifdef BRIDGE_BYTE_MASK_EN
        WMASK: begin
          if (in_xfer) begin
            mask <= IN_DATA[3:0];
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        WDATA: begin
          if (in_xfer) begin
            wdata[{bcnt, 3'b000} +: 8] <= IN_DATA;
            bcnt <= bcnt + 1'b1;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // RAM output register is valid only in this cycle
        RCAP: begin
          shreg <= RAM_DO;
          ocnt  <= '0;
        end
        RSEND: begin
          if (out_xfer) begin
            shreg <= {8'h00, shreg[31:8]};
            ocnt  <= ocnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram32_byte_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for ram32_byte_bridge: directed byte streams feed expected RAM
// accesses and output bytes into queues that independent monitors pop and compare.
module tb_ram32_byte_bridge;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        ABORT;
  logic        RAM_EN;
  logic [3:0]  RAM_WE;
  logic [4:0]  RAM_A;
  logic [31:0] RAM_DI;
  logic [31:0] RAM_DO;

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  a;
    logic [31:0] di;
    bit          isWr;
  } ramOp_t;

  ramOp_t      ramQ[$];
  logic [7:0]  outQ[$];
  int          testsRun    = 0;
  int          testsFailed = 0;
  int          abortCount  = 0;
  int          expAborts   = 0;
  logic [31:0] mem [32];

  ram32_byte_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ABORT(ABORT),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM macro model: registered output, zero on any cycle EN was low
  initial begin
    logic [31:0] rd;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | i;
    RAM_DO = 32'd0;
    forever begin
      @(posedge CLK);
      if (RAM_EN) begin
        rd = mem[RAM_A];
        for (int i = 0; i < 4; i++)
          if (RAM_WE[i]) mem[RAM_A][i*8 +: 8] = RAM_DI[i*8 +: 8];
        RAM_DO <= rd;
      end else begin
        RAM_DO <= 32'd0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // RAM access monitor
  always @(negedge CLK) begin
    if (RST_N && RAM_EN) begin
      if (ramQ.size() == 0) begin
        checkOutput("ram_en_unexpected", 32'(RAM_EN), 32'd0);
      end else begin
        ramOp_t op;
        op = ramQ.pop_front();
        checkOutput("ram_we", 32'(RAM_WE), 32'(op.we));
        checkOutput("ram_addr", 32'(RAM_A), 32'(op.a));
        if (op.isWr) checkOutput("ram_di", RAM_DI, op.di);
      end
    end
  end

  // Output byte monitor, including stability under backpressure
  always @(negedge CLK) begin
    if (RST_N && OUT_VALID) begin
      if (outQ.size() == 0) begin
        checkOutput("out_valid_unexpected", 32'(OUT_VALID), 32'd0);
      end else if (OUT_READY) begin
        logic [7:0] b;
        b = outQ.pop_front();
        checkOutput("out_byte", 32'(OUT_DATA), 32'(b));
      end else begin
        checkOutput("out_stall_hold", 32'(OUT_DATA), 32'(outQ[0]));
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N && ABORT) abortCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    IN_DATA  = b;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) checkOutput("in_accept_timeout", 32'(IN_READY), 32'd1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic waitOutDrain();
    int n;
    n = 0;
    while (outQ.size() != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    #1;
    if (outQ.size() != 0) begin
      checkOutput("out_drain_timeout", 32'(outQ.size()), 32'd0);
      outQ.delete();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(IN_READY), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(OUT_DATA), 32'd0);
    checkOutput({tag, "_abort"}, 32'(ABORT), 32'd0);
    checkOutput({tag, "_ram_en"}, 32'(RAM_EN), 32'd0);
    checkOutput({tag, "_ram_we"}, 32'(RAM_WE), 32'd0);
    checkOutput({tag, "_ram_a"}, 32'(RAM_A), 32'd0);
    checkOutput({tag, "_ram_di"}, RAM_DI, 32'd0);
  endtask

  // we doubles as the mask byte when the mask feature is built in
  task automatic writeWord(input logic [4:0] a, input logic [3:0] we, input logic [31:0] word);
    ramOp_t op;
    op.a    = a;
    op.we   = we;
    op.di   = word;
    op.isWr = 1'b1;
    ramQ.push_back(op);
    applyStimulus({3'b100, a});
`ifdef BRIDGE_BYTE_MASK_EN
    applyStimulus({4'h0, we});
`endif
    for (int i = 0; i < 4; i++) applyStimulus(word[i*8 +: 8]);
    checkOutput("wr_en_latency", 32'(RAM_EN), 32'd1);
    checkOutput("wr_in_ready_low", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("wr_en_single", 32'(RAM_EN), 32'd0);
  endtask

  task automatic readWord(input logic [4:0] a, input logic [31:0] word);
    ramOp_t op;
    op.a    = a;
    op.we   = 4'h0;
    op.di   = 32'd0;
    op.isWr = 1'b0;
    ramQ.push_back(op);
    for (int i = 0; i < 4; i++) outQ.push_back(word[i*8 +: 8]);
    OUT_READY = 1'b1;
    applyStimulus({3'b000, a});
    waitOutDrain();
    checkOutput("rd_done_idle", 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    ramOp_t op;
    RST_N     = 1'b0;
    IN_DATA   = 8'h00;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;

    // Power-on reset and release
    repeat (3) @(posedge CLK);
    #1;
    checkAllZero("por");
    RST_N = 1'b1;
    #1;
    checkOutput("por_ready_before_edge", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("por_ready_after_edge", 32'(IN_READY), 32'd1);

    // Plain write of 0x12345678 to address 5
    writeWord(5'd5, 4'hF, 32'h1234_5678);

    // Read with backpressure
    OUT_READY = 1'b0;
    op.a = 5'd5; op.we = 4'h0; op.di = 32'd0; op.isWr = 1'b0;
    ramQ.push_back(op);
    outQ.push_back(8'h78); outQ.push_back(8'h56); outQ.push_back(8'h34); outQ.push_back(8'h12);
    applyStimulus(8'h05);
    checkOutput("rd_en_latency", 32'(RAM_EN), 32'd1);
    checkOutput("rd_we_zero", 32'(RAM_WE), 32'd0);
    checkOutput("rd_valid_c1", 32'(OUT_VALID), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("rd_en_c2", 32'(RAM_EN), 32'd0);
    checkOutput("rd_valid_c2", 32'(OUT_VALID), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("rd_valid_c3", 32'(OUT_VALID), 32'd1);
    repeat (10) @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    waitOutDrain();
    checkOutput("rd_bp_idle", 32'(OUT_VALID), 32'd0);

    // Reset in the middle of a write: nothing committed
    applyStimulus(8'h81);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    #1;
    RST_N = 1'b0;
    #1;
    checkAllZero("mid_wr_rst");
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    #1;
    checkOutput("mid_wr_ready_before_edge", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("mid_wr_ready_after_edge", 32'(IN_READY), 32'd1);
    readWord(5'd1, 32'hA500_0001);

    // Timeout drops a partial write
    applyStimulus(8'h83);
`ifdef BRIDGE_BYTE_MASK_EN
    applyStimulus(8'h0F);
`endif
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    repeat (TIMEOUT - 1) @(posedge CLK);
    #1;
    checkOutput("abort_early", 32'(ABORT), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("abort_pulse", 32'(ABORT), 32'd1);
    checkOutput("abort_back_idle", 32'(IN_READY), 32'd1);
    expAborts++;
    @(posedge CLK);
    #1;
    checkOutput("abort_single", 32'(ABORT), 32'd0);
    readWord(5'd3, 32'hA500_0003);

    // Bytes accepted just in time keep the write alive
    op.a = 5'd3; op.we = 4'hF; op.di = 32'h0403_0201; op.isWr = 1'b1;
    ramQ.push_back(op);
    applyStimulus(8'h83);
`ifdef BRIDGE_BYTE_MASK_EN
    applyStimulus(8'h0F);
`endif
    applyStimulus(8'h01);
    repeat (TIMEOUT - 1) @(posedge CLK);
    #1;
    applyStimulus(8'h02);
    repeat (TIMEOUT - 2) @(posedge CLK);
    #1;
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    checkOutput("to_boundary_en", 32'(RAM_EN), 32'd1);
    checkOutput("to_boundary_no_abort", 32'(ABORT), 32'd0);
    @(posedge CLK);
    #1;
    readWord(5'd3, 32'h0403_0201);

    // Reset while byte2 of a read is on the output
    op.a = 5'd5; op.we = 4'h0; op.di = 32'd0; op.isWr = 1'b0;
    ramQ.push_back(op);
    outQ.push_back(8'h78); outQ.push_back(8'h56);
    OUT_READY = 1'b1;
    applyStimulus(8'h05);
    waitOutDrain();
    OUT_READY = 1'b0;
    checkOutput("rst_rd_valid_before", 32'(OUT_VALID), 32'd1);
    checkOutput("rst_rd_byte2", 32'(OUT_DATA), 32'h34);
    #1;
    RST_N = 1'b0;
    #1;
    checkAllZero("mid_rd_rst");
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    readWord(5'd5, 32'h1234_5678);

`ifdef BRIDGE_BYTE_MASK_EN
    // Partial-byte write and an all-zero mask
    writeWord(5'd2, 4'b0101, 32'h4433_2211);
    readWord(5'd2, 32'hA533_0011);
    writeWord(5'd2, 4'b0000, 32'hDEAD_BEEF);
    readWord(5'd2, 32'hA533_0011);
`endif

    repeat (5) @(posedge CLK);
    #1;
    checkOutput("abort_count", 32'(abortCount), 32'(expAborts));
    checkOutput("ram_queue_drained", 32'(ramQ.size()), 32'd0);
    checkOutput("out_queue_drained", 32'(outQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
